// File: rtl/rv32i_types_pkg.sv
// Shared RV32I decode types plus the RISC-MGMT arbiter state and bubble-counter width.
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    localparam int RMGMT_BUBBLE_CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // True when more than one bit of the (zero-extended) claim vector is set.
    function automatic logic more_than_one(input logic [7:0] v);
        return ((v & (v - 8'd1)) != 8'd0);
    endfunction

endpackage

// File: rtl/risc_mgmt_prio_enc.sv
// N-wide priority encoder; search starts at index ptr and wraps, lowest offset wins.
module risc_mgmt_prio_enc
    import rv32i_types_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);
    localparam int SW = IDX_W + 1;

    logic [SW-1:0] w_cand;

    // Walk the requests starting from ptr, wrapping modulo N, and keep the first hit.
    always_comb begin
        valid  = 1'b0;
        idx    = {IDX_W{1'b0}};
        w_cand = {SW{1'b0}};
        for (int i = 0; i < N; i++) begin
            w_cand = {1'b0, ptr} + SW'(i);
            if (w_cand >= SW'(N)) begin
                w_cand = w_cand - SW'(N);
            end else begin
                w_cand = w_cand;
            end
            if (!valid && req[w_cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = w_cand[IDX_W-1:0];
            end else begin
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/risc_mgmt_decode_arb.sv
// Decode-stage arbiter granting the instruction to one RISC-MGMT extension and policing bubbles.
// Build option: define RISC_MGMT_RR_ARB_EN for round-robin arbitration (fixed priority otherwise).
module risc_mgmt_decode_arb
    import rv32i_types_pkg::*;
#(
    parameter int N_EXT          = 4,
    parameter int BUBBLE_TIMEOUT = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  word_t                      insn,
    input  logic                       insn_valid,
    input  logic                       flush,
    input  logic                       pipe_stall,
    output word_t                      ext_insn,
    input  logic [N_EXT-1:0]           ext_claim,
    input  logic [N_EXT-1:0]           ext_bubble_req,
    input  logic [N_EXT-1:0][4:0]      ext_rsel_s_0,
    input  logic [N_EXT-1:0][4:0]      ext_rsel_s_1,
    input  logic [N_EXT-1:0][4:0]      ext_rsel_d,
    output logic                       claimed,
    output logic [$clog2(N_EXT)-1:0]   owner_id,
    output logic [4:0]                 rsel_s_0,
    output logic [4:0]                 rsel_s_1,
    output logic [4:0]                 rsel_d,
    output logic                       decode_bubble,
    output logic                       multi_claim,
    output logic                       timeout_err
);
    localparam int IDX_W = $clog2(N_EXT);
    localparam int CW    = RMGMT_BUBBLE_CNT_W;
    localparam logic [CW-1:0] TIMEOUT_C = CW'(BUBBLE_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX_C = {CW{1'b1}};

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] w_owner_nxt;
    logic [IDX_W-1:0] w_ptr;
    logic [IDX_W-1:0] w_enc_idx;
    logic [IDX_W-1:0] w_sel_idx;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_enc_valid;
    logic             w_grant;
    logic             w_route;
    logic             w_kill;
    logic             w_breq;

    assign ext_insn = insn;
    // Reset behaves like flush for the pulse outputs so an abandoned claim never reports a timeout.
    assign w_kill   = flush | RST;
    assign w_breq   = ext_bubble_req[r_owner];

    risc_mgmt_prio_enc #(
        .N     (N_EXT),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req   (ext_claim),
        .ptr   (w_ptr),
        .valid (w_enc_valid),
        .idx   (w_enc_idx)
    );

`ifdef RISC_MGMT_RR_ARB_EN
    logic [IDX_W-1:0] r_rr_ptr;

    // Round-robin pointer: the slot after the most recent winner gets top priority.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rr_ptr <= {IDX_W{1'b0}};
        end else if (w_grant) begin
            r_rr_ptr <= (w_enc_idx == IDX_W'(N_EXT - 1)) ? {IDX_W{1'b0}} : (w_enc_idx + IDX_W'(1));
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    assign w_ptr = r_rr_ptr;
`else
    assign w_ptr = {IDX_W{1'b0}};
`endif

    // Next-state, counter and output decode for the IDLE/OWN arbiter.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_cnt_nxt     = r_cnt;
        w_grant       = 1'b0;
        w_route       = 1'b0;
        w_sel_idx     = r_owner;
        claimed       = 1'b0;
        owner_id      = r_owner;
        decode_bubble = 1'b0;
        multi_claim   = 1'b0;
        timeout_err   = 1'b0;
        rsel_s_0      = 5'd0;
        rsel_s_1      = 5'd0;
        rsel_d        = 5'd0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = {CW{1'b0}};
                if (insn_valid && w_enc_valid && !pipe_stall && !w_kill) begin
                    w_grant     = 1'b1;
                    w_route     = 1'b1;
                    w_sel_idx   = w_enc_idx;
                    claimed     = 1'b1;
                    owner_id    = w_enc_idx;
                    multi_claim = more_than_one(8'(ext_claim));
                    w_owner_nxt = w_enc_idx;
                    w_state_nxt = OWN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            OWN: begin
                w_route = 1'b1;
                claimed = 1'b1;
                if (w_kill) begin
                    decode_bubble = w_breq;
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = {CW{1'b0}};
                end else if (pipe_stall) begin
                    decode_bubble = w_breq;
                end else if (w_breq && (r_cnt >= TIMEOUT_C)) begin
                    timeout_err = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = {CW{1'b0}};
                end else if (w_breq) begin
                    decode_bubble = 1'b1;
                    w_cnt_nxt     = (r_cnt == CNT_MAX_C) ? r_cnt : (r_cnt + CW'(1));
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = {CW{1'b0}};
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase
        if (w_route) begin
            rsel_s_0 = ext_rsel_s_0[w_sel_idx];
            rsel_s_1 = ext_rsel_s_1[w_sel_idx];
            rsel_d   = ext_rsel_d[w_sel_idx];
        end else begin
            rsel_s_0 = 5'd0;
            rsel_s_1 = 5'd0;
            rsel_d   = 5'd0;
        end
    end

    // State, owner and bubble-counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_owner <= {IDX_W{1'b0}};
            r_cnt   <= {CW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: doc/risc_mgmt_decode_arb.md
RISC_MGMT_DECODE_ARB -- requirements
Module: risc_mgmt_decode_arb

Interface
REQ-001 SHALL have parameter N_EXT, default 4, number of RISC-MGMT extensions (2..8).
REQ-002 SHALL have parameter BUBBLE_TIMEOUT, default 16, max consecutive bubble cycles per claim (1..255).
REQ-003 SHALL have the following ports. Clock is CLK. Reset is RST: one clock, synchronous, active-high.
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- insn  in  32  decode-stage instruction word (word_t).
- insn_valid  in  1  insn valid this cycle.
- flush  in  1  pipeline flush.
- pipe_stall  in  1  downstream stall; freezes arbiter.
- ext_insn  out  32  insn broadcast to all extensions.
- ext_claim  in  N_EXT  per-extension insn_claim.
- ext_bubble_req  in  N_EXT  per-extension bubble_req.
- ext_rsel_s_0, ext_rsel_s_1, ext_rsel_d  in  N_EXT x 5  per-extension register selects.
- claimed  out  1  an extension owns the current insn.
- owner_id  out  $clog2(N_EXT)  owning extension index.
- rsel_s_0, rsel_s_1, rsel_d  out  5  owner's selects; 0 when unclaimed.
- decode_bubble  out  1  insert bubble / hold decode.
- multi_claim  out  1  one-cycle pulse: more than one claim seen at arbitration.
- timeout_err  out  1  one-cycle pulse: owner exceeded BUBBLE_TIMEOUT.

Function
REQ-004 SHALL drive ext_insn = insn combinationally at all times.
REQ-005 SHALL implement states IDLE and OWN.
REQ-006 In IDLE with insn_valid & |ext_claim & !pipe_stall & !flush, SHALL grant one claimant in the same cycle, latch owner_id, and go to OWN. claimed and the rsel outputs are valid combinationally in the grant cycle.
REQ-007 SHALL pulse multi_claim in the grant cycle when popcount(ext_claim) > 1.
REQ-008 In IDLE with no grant, SHALL drive claimed=0, rsel_*=0 and decode_bubble=0.
REQ-009 In OWN, SHALL drive claimed=1, route rsel_* from owner_id, and drive decode_bubble = ext_bubble_req[owner_id].
- ext_claim/ext_bubble_req of non-owners are ignored.
REQ-010 In OWN, SHALL increment an 8-bit bubble counter each cycle decode_bubble=1 & !pipe_stall, saturating at 255.
- Counter clears on every entry to IDLE.
REQ-011 In OWN with ext_bubble_req[owner_id]=0 & !pipe_stall, SHALL return to IDLE on the next edge (insn retired from decode).
REQ-012 When the counter reaches BUBBLE_TIMEOUT while bubble is still requested, SHALL pulse timeout_err, force decode_bubble=0 that cycle, and return to IDLE.
REQ-013 While pipe_stall=1, SHALL hold state, owner_id and counter; outputs reflect held state.
REQ-014 flush SHALL force IDLE on the next edge from any state and suppress grant, multi_claim and timeout_err in that cycle. flush has priority over pipe_stall.
REQ-015 A claim arriving with insn_valid=0 SHALL be ignored.
REQ-016 Grant and timeout in the same cycle is impossible by construction. A new grant SHALL NOT occur in the cycle OWN->IDLE is taken; earliest re-grant is the following cycle.

Reset
REQ-017 On RST=1 at a CLK edge, SHALL set state=IDLE, owner_id=0, counter=0, RR pointer=0.
- All outputs take their IDLE values (claimed=0, rsel_*=0, decode_bubble=0, multi_claim=0, timeout_err=0).
REQ-018 RST asserted mid-OWN SHALL abandon the claim without a timeout_err pulse.

Configuration
REQ-019 With macro RISC_MGMT_RR_ARB_EN defined, SHALL arbitrate round-robin.
- Priority starts at RR pointer.
- After each grant, pointer = owner_id+1 mod N_EXT.
REQ-020 Without RISC_MGMT_RR_ARB_EN, SHALL use fixed priority (lowest index wins); no pointer register is built.

Structure
REQ-021 SHALL place arb_state_t (IDLE, OWN) and the RMGMT_BUBBLE_CNT_W=8 constant in rv32i_types_pkg alongside word_t.
REQ-022 SHALL instantiate one sub-module, risc_mgmt_prio_enc: N_EXT-wide priority encoder with rotate-by-pointer input (pointer tied 0 when round-robin disabled).

Verification
REQ-023 Reset: RST=1 two cycles, then 0 -> claimed=0, decode_bubble=0, rsel_*=0 on first post-reset cycle.
REQ-024 Single claim: insn_valid=1, ext_claim=4'b0100, ext_rsel_d[2]=5'd7 -> same cycle claimed=1, owner_id=2, rsel_d=7. Next cycle with bubble_req[2]=0 -> IDLE.
REQ-025 Contention: ext_claim=4'b0110 three times back-to-back -> multi_claim pulses each grant. Fixed priority: owner 1,1,1. Round-robin: owner 1,2,1.
REQ-026 Timeout: BUBBLE_TIMEOUT=4, owner holds bubble_req=1 -> decode_bubble=1 for 4 cycles, timeout_err pulse on 5th, then IDLE.
REQ-027 Stall/flush: in OWN with counter=2, pipe_stall=1 for 3 cycles -> counter stays 2. Then flush=1 with pipe_stall=1 -> IDLE next edge, no timeout_err.
REQ-028 Reset mid-OWN: RST=1 during bubble -> IDLE, counter=0, no timeout_err pulse.
